inst_mem_fetch: RTL and testbench

Parametrised successor to the single-cycle instruction memory. It is a word-organised instruction store with a valid/ready fetch handshake, one registered response stage, alignment and range checking, a program-load write port and a flush input. It sits between the PC/fetch stage and the decode stage of the MIPS datapath, and it delivers both the raw instruction word and the pre-split R/I/J fields.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/inst_field_split.sv | 22 ++
 rtl/inst_mem_fetch.sv | 107 ++++++++++
 tb/tb_inst_mem_fetch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: instruction field widths, the NOP encoding and
// the pre-split instruction field record used by fetch and decode.
package mips_pkg;

  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // R, I and J views overlap; consumers pick the ones their format needs.
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
    logic [JADDR_W-1:0] jaddr;
  } inst_fields_t;

endpackage

// File: rtl/inst_field_split.sv
// Combinational split of a 32-bit MIPS word into its R/I/J fields.
// Shared by the fetch response path and the decode stage.
module inst_field_split
  import mips_pkg::*;
(
  input  logic [31:0]  inst,
  output inst_fields_t fields
);

  always_comb begin
    fields        = '0;
    fields.opcode = inst[31:26];
    fields.rs     = inst[25:21];
    fields.rt     = inst[20:16];
    fields.rd     = inst[15:11];
    fields.shamt  = inst[10:6];
    fields.funct  = inst[5:0];
    fields.imm    = inst[15:0];
    fields.jaddr  = inst[25:0];
  end

endmodule

// File: rtl/inst_mem_fetch.sv
// Word-organised instruction store with valid/ready fetch, one registered
// response stage, alignment/range checking, a program-load port and flush.
module inst_mem_fetch
  import mips_pkg::*;
#(
  parameter int    DEPTH     = 64,
  parameter int    AW        = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          flush,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic          rsp_err,
  output logic [5:0]    opcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    funct,
  output logic [15:0]   imm,
  output logic [25:0]   jaddr,
  output logic [15:0]   err_count
);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rdata_q;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   err_count_q, err_count_d;
  logic          accept;
  logic          req_bad;
  logic [AW-1:0] req_idx;
  inst_fields_t  fields;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_comb begin
    req_ready = !ld_en && (!rsp_valid_q || rsp_ready);
    accept    = req_valid && req_ready && !flush;
    req_idx   = req_addr[AW+1:2];
    req_bad   = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);

    rsp_valid_d = rsp_valid_q;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    if (accept)                   rsp_valid_d = 1'b1;
    if (flush)                    rsp_valid_d = 1'b0;

    rsp_err_d = accept ? req_bad : rsp_err_q;

    err_count_d = err_count_q;
    if (accept && req_bad && (err_count_q != 16'hFFFF))
      err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Array write and registered read kept apart so the store maps to block RAM.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset)       rdata_q <= '0;
    else if (accept) rdata_q <= mem[req_idx];
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;
  assign rsp_inst  = rsp_err_q ? NOP_INST : rdata_q;

  inst_field_split u_split (
    .inst   (rsp_inst),
    .fields (fields)
  );

  assign opcode = fields.opcode;
  assign rs     = fields.rs;
  assign rt     = fields.rt;
  assign rd     = fields.rd;
  assign shamt  = fields.shamt;
  assign funct  = fields.funct;
  assign imm    = fields.imm;
  assign jaddr  = fields.jaddr;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Bench for inst_mem_fetch: table-driven fetches plus stall, load, flush and
// reset sequences, checked through a response scoreboard.
module tb_inst_mem_fetch;
  import mips_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          flush = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_inst;
  logic          rsp_err;
  logic [5:0]    opcode;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   jaddr;
  logic [15:0]   err_count;

  inst_mem_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst), .rsp_err(rsp_err), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .jaddr(jaddr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          cyc;
    bit          chk_lat;
    int          ec;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[11];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ec_mdl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] inst, input logic err, input bit chk_lat);
    exp_t e;
    if (err) ec_mdl++;
    e.inst = inst; e.err = err; e.cyc = cyc + 1; e.chk_lat = chk_lat; e.ec = ec_mdl;
    sb.push_back(e);
  endtask

  // Holds the request until a negedge shows req_ready, then records the expectation.
  task automatic send(input logic [31:0] addr, input logic [31:0] inst, input logic err,
                      input bit chk_lat);
    bit ok;
    ok = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_ready %b for addr %h, expected 1", req_ready, addr);
    end else begin
      push(inst, err, chk_lat);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    check("ld_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_inst %h, expected no response", rsp_inst);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_inst", rsp_inst, mon_e.inst);
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        check("rsp_fields", {opcode, rs, rt, rd, shamt, funct}, mon_e.inst);
        check("rsp_imm", 32'(imm), {16'h0, mon_e.inst[15:0]});
        check("rsp_jaddr", 32'(jaddr), {6'h0, mon_e.inst[25:0]});
        check("err_count", 32'(err_count), 32'(mon_e.ec));
        if (mon_e.chk_lat) check("rsp_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) vecs[i] = '{32'(4 * i), 32'h20 + 32'(i), 1'b0};
    vecs[6]  = '{32'h0000_0006, NOP_INST, 1'b1};
    vecs[7]  = '{32'(DEPTH * 4), NOP_INST, 1'b1};
    vecs[8]  = '{32'h0000_0014, 32'h0000_0025, 1'b0};
    vecs[9]  = '{32'h8000_0000, NOP_INST, 1'b1};
    vecs[10] = '{32'h0000_0002, NOP_INST, 1'b1};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_inst", rsp_inst, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 6; i++) load(AW'(i), 32'h20 + 32'(i));

    // Back-to-back fetches with the consumer always ready.
    for (int i = 0; i < 11; i++) send(vecs[i].addr, vecs[i].inst, vecs[i].err, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("tbl_err_count", 32'(err_count), 32'(ec_mdl));

    // Stalled response for addr 8, next request waiting behind it.
    rsp_ready = 1'b0;
    send(32'h8, 32'h22, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_addr  = 32'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'h1);
      check("stall_inst", rsp_inst, 32'h22);
      check("stall_funct", 32'(funct), 32'h22);
      check("stall_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release_req_ready", 32'(req_ready), 32'h1);
    push(32'h23, 1'b0, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    // Load while a request is presented, then fetch the new word.
    ld_en = 1'b1; ld_addr = 6'd3; ld_data = 32'h0123_4567;
    req_valid = 1'b1; req_addr = 32'hC;
    @(negedge clk);
    check("ld_cycle_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 ld_en = 1'b0;
    send(32'hC, 32'h0123_4567, 1'b0, 1'b1);
    @(negedge clk);
    check("ld_opcode", 32'(opcode), 32'd0);
    check("ld_rs", 32'(rs), 32'd9);
    check("ld_rt", 32'(rt), 32'd3);
    check("ld_rd", 32'(rd), 32'd8);
    check("ld_shamt", 32'(shamt), 32'd21);
    check("ld_funct", 32'(funct), 32'h27);

    // Flush a stalled response together with an erroring request.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(32'h0, 32'h20, 1'b0, 1'b0);
    req_valid = 1'b1; req_addr = 32'h6; flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    check("flush_err_count", 32'(err_count), 32'(ec_mdl));
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset while a response is stalled.
    #1 rsp_ready = 1'b0;
    send(32'h10, 32'h24, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    ec_mdl = 0;
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_rsp_inst", rsp_inst, 32'h0);
    check("mid_rst_rsp_err", 32'(rsp_err), 32'h0);
    check("mid_rst_err_count", 32'(err_count), 32'h0);
    check("mid_rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
    check("mid_rst_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send(32'hC, 32'h0123_4567, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
